// File: rtl/semi_serial_layer.sv
// semi_serial_layer: M-neuron fully-connected layer computed over K parallel
// MAC lanes, with bias, saturation and selectable activation per neuron.
// valid/ready handshakes on both sides; a job is accepted only when idle.
module semi_serial_layer #(
    parameter int N  = 4,
    parameter int M  = 2,
    parameter int K  = 2,
    parameter int QM = 12,
    parameter int QN = 20,
    parameter int WM = 6,
    parameter int WN = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [N-1:0][QM+QN-1:0]              in,
    input  logic [M-1:0][N-1:0][WM+WN-1:0]       weights,
    input  logic [M-1:0][QM+QN-1:0]              bias,
    input  logic [1:0]                           act_mode,
    output logic [M-1:0][QM+QN-1:0]              out,
    output logic                                 out_valid,
    input  logic                                 out_ready
);

    localparam int DW = QM + QN;
    localparam int WW = WM + WN;
    localparam int PW = DW + WW;
    localparam int AW = PW + $clog2(N + 1) + 1;
    localparam int SW = AW - WN;
    localparam int IW = $clog2(N + K + 1);
    localparam int MW = (M > 1) ? $clog2(M) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MAC  = 3'd1;
    localparam logic [2:0] S_BIAS = 3'd2;
    localparam logic [2:0] S_ACT  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    logic [2:0]                     state_q, state_d;
    logic [IW-1:0]                  i_q, i_d;
    logic [MW-1:0]                  m_q, m_d;
    logic signed [AW-1:0]           acc_q [K];
    logic signed [AW-1:0]           acc_d [K];
    logic signed [SW-1:0]           sum_q, sum_d;
    logic [N-1:0][DW-1:0]           in_q, in_d;
    logic [M-1:0][N-1:0][WW-1:0]    w_q, w_d;
    logic [M-1:0][DW-1:0]           bias_q, bias_d;
    logic [1:0]                     mode_q, mode_d;
    logic [M-1:0][DW-1:0]           out_q, out_d;
    logic                           out_valid_q, out_valid_d;

    logic [N-1:0][WW-1:0]           wsel;
    logic [DW-1:0]                  bsel;
    logic [IW-1:0]                  idx;
    logic signed [PW-1:0]           prod;
    logic signed [AW-1:0]           tot;
    logic [SW-DW:0]                 guard;
    logic signed [DW-1:0]           sat;
    logic signed [DW-1:0]           act;

    // Operand selection for the current neuron, saturation and activation.
    always_comb begin
        wsel = '0;
        bsel = '0;
        for (int unsigned mm = 0; mm < M; mm++) begin
            if (m_q == MW'(mm)) begin
                wsel = w_q[mm];
                bsel = bias_q[mm];
            end
        end

        // sum_q already has the WN weight-fraction bits dropped (floor);
        // everything above the DW result bits must equal the sign bit.
        guard = sum_q[SW-1:DW-1];
        if (guard == '0 || guard == '1) begin
            sat = sum_q[DW-1:0];
        end else if (sum_q[SW-1]) begin
            sat = {1'b1, {(DW-1){1'b0}}};
        end else begin
            sat = {1'b0, {(DW-1){1'b1}}};
        end

        case (mode_q)
            2'd0:    act = sat[DW-1] ? '0 : sat;
            2'd2:    act = sat[DW-1] ? (sat >>> 3) : sat;
            default: act = sat;
        endcase
    end

    // Next-state logic for the control FSM and datapath registers.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        m_d         = m_q;
        sum_d       = sum_q;
        in_d        = in_q;
        w_d         = w_q;
        bias_d      = bias_q;
        mode_d      = mode_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        idx         = '0;
        prod        = '0;
        tot         = '0;
        for (int unsigned k = 0; k < K; k++) begin
            acc_d[k] = acc_q[k];
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    in_d    = in;
                    w_d     = weights;
                    bias_d  = bias;
                    mode_d  = act_mode;
                    i_d     = '0;
                    m_d     = '0;
                    for (int unsigned k = 0; k < K; k++) begin
                        acc_d[k] = '0;
                    end
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                // Lanes whose element index falls past N-1 match no n and hold.
                for (int unsigned k = 0; k < K; k++) begin
                    idx = i_q + IW'(k);
                    for (int unsigned n = 0; n < N; n++) begin
                        if (idx == IW'(n)) begin
                            prod     = PW'($signed(in_q[n])) * PW'($signed(wsel[n]));
                            acc_d[k] = acc_q[k] + AW'(prod);
                        end
                    end
                end
                i_d = i_q + IW'(K);
                if (i_q + IW'(K) >= IW'(N)) begin
                    state_d = S_BIAS;
                end
            end
            S_BIAS: begin
                tot = AW'($signed(bsel)) <<< WN;
                for (int unsigned k = 0; k < K; k++) begin
                    tot = tot + acc_q[k];
                end
                sum_d   = tot[AW-1:WN];
                state_d = S_ACT;
            end
            S_ACT: begin
                for (int unsigned mm = 0; mm < M; mm++) begin
                    if (m_q == MW'(mm)) begin
                        out_d[mm] = act;
                    end
                end
                for (int unsigned k = 0; k < K; k++) begin
                    acc_d[k] = '0;
                end
                if (m_q == MW'(M - 1)) begin
                    state_d = S_OUT;
                end else begin
                    m_d     = m_q + 1'b1;
                    i_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_OUT: begin
                // out_valid rises one cycle after entering OUT, giving the
                // M*(ceil(N/K)+2)+1 accept-to-valid latency.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            m_q         <= '0;
            sum_q       <= '0;
            in_q        <= '0;
            w_q         <= '0;
            bias_q      <= '0;
            mode_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            for (int unsigned k = 0; k < K; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            m_q         <= m_d;
            sum_q       <= sum_d;
            in_q        <= in_d;
            w_q         <= w_d;
            bias_q      <= bias_d;
            mode_q      <= mode_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            for (int unsigned k = 0; k < K; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule
